mem_arb: RTL and testbench
==========================

# mem_arb

Two-port to one-port memory arbiter for the MINA CPU. It lets the instruction-fetch port (IMEM) and the data-access port (DMEM) share one external 32-bit memory bus. Each transaction is latched, presented on the bus until the bus acknowledges it, and answered with a registered one-cycle ready pulse. Arbitration is DMEM-priority, with a bounded-streak rule so fetch cannot starve.

## Interface
- MAX_D_STREAK, default 4: number of consecutive DMEM grants allowed while IMEM is waiting; legal range 1..15.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- imem_req  in  1  fetch request; held with imem_addr stable until imem_ready
- imem_addr  in  32  fetch word address
- imem_rdata  out  32  fetch data; valid while imem_ready=1
- imem_ready  out  1  one-cycle completion pulse for fetch
- dmem_req  in  1  data request; held with addr/wrdata/wrstb stable until dmem_ready
- dmem_addr  in  32  data address
- dmem_wrdata  in  32  store data
- dmem_wrstb  in  4  byte write strobes; 4'b0000 means read
- dmem_rdata  out  32  load data; valid while dmem_ready=1
- dmem_ready  out  1  one-cycle completion pulse for data
- bus_valid  out  1  transaction valid on the bus
- bus_addr  out  32  bus address
- bus_wrdata  out  32  bus store data
- bus_wrstb  out  4  bus byte strobes
- bus_rddata  in  32  bus read data; sampled when bus_ready=1
- bus_ready  in  1  bus acknowledge
- grant_d  out  1  1 while the current or last owner is DMEM (debug)

## Operation
- FSM has three states: IDLE, BUSY, RESP. The reset state is IDLE.
- **IDLE**
  - No request: stay in IDLE.
  - Only one requester: grant it.
  - Both requesting: grant DMEM unless streak==MAX_D_STREAK, in which case grant IMEM.
  - On a grant: latch addr, wrdata and wrstb into the bus_* registers. For an IMEM grant, wrdata=0 and wrstb=0. Set grant_d and go to BUSY.
- **BUSY**
  - bus_valid=1 and the bus_* outputs are constant.
  - On bus_ready=1: capture bus_rddata into the owner's rdata register, assert the owner's ready, clear bus_valid, go to RESP.
  - Captured data is undefined for writes but is still driven.
- **RESP**
  - Exactly one of imem_ready/dmem_ready is 1. No grant is made in this state.
  - Next state is IDLE.
- **Streak counter** (4 bits, updated at grant time):
  - DMEM grant with imem_req=1: increment, saturating at MAX_D_STREAK.
  - DMEM grant with imem_req=0: clear to 0.
  - Any IMEM grant: clear to 0.
- rdata registers hold their value after the ready pulse until the next capture for the same port.
- Requests made during BUSY or RESP wait; they are not lost, because the requester holds req.
- Dropping req during BUSY has no effect: the latched transaction completes and the ready pulse is still generated.

## Timing
- Reset values:
  - bus_valid=0, bus_addr=0, bus_wrdata=0, bus_wrstb=0.
  - imem_ready=0, dmem_ready=0, imem_rdata=0, dmem_rdata=0.
  - grant_d=0, streak=0, state=IDLE.
- Reset asserted mid-transaction abandons it: no ready pulse, and bus_valid=0 on the next cycle.
- Latency, with req first seen at edge N:
  - bus_valid=1 from cycle N+1.
  - bus_ready sampled at edge N+1+k, where k≥0 is the number of wait cycles.
  - The ready pulse occupies cycle N+2+k.
  - The next grant is possible at the edge ending cycle N+3+k.
- Minimum is 3 cycles per transaction (zero-wait bus). Back-to-back throughput is one transaction per 3 cycles.
- A requester sees ready=1 and may change or drop req on the following edge. Because RESP never grants, a stale req is never re-granted.
- bus_ready while bus_valid=0 is ignored.

## Test plan
- **Single fetch, zero-wait bus.** Stimulus: imem_req=1, imem_addr=0x00000010, bus returns 0xDEADBEEF. Required: bus_valid for exactly 1 cycle with bus_addr=0x10 and bus_wrstb=0; imem_ready pulse 1 cycle later with imem_rdata=0xDEADBEEF; dmem_ready stays 0.
- **Store with 3 wait cycles.** Stimulus: dmem_req=1, addr 0x100, wrdata 0x12345678, wrstb 4'b0011. Required: bus_* held stable for 4 cycles; dmem_ready on the cycle after bus_ready; total latency 6 cycles.
- **Simultaneous requests, MAX_D_STREAK=2.** Stimulus: both req held continuously, DMEM re-requesting each time. Required: grant order D, D, I, D, D, I; grant_d matches this order.
- **Streak reset.** Stimulus: DMEM grant with imem_req=0, then both request. Required: DMEM is granted (streak was cleared to 0).
- **Reset during BUSY.** Stimulus: rst_n low for 1 cycle while bus_valid=1. Required: bus_valid=0 and both readies 0 on the next cycle; no ready pulse ever appears for the abandoned transaction; a new fetch afterwards completes normally.
- **Requester drops req during BUSY.** Stimulus: imem_req deasserted 1 cycle after grant. Required: the transaction still completes and imem_ready pulses once.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port (fetch/data) to one-port memory bus arbiter with DMEM priority and a
// bounded DMEM streak so a waiting fetch is always served eventually.
module mem_arb #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_req,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wrdata,
    input  logic [3:0]  dmem_wrstb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wrdata,
    output logic [3:0]  bus_wrstb,
    input  logic [31:0] bus_rddata,
    input  logic        bus_ready,
    output logic        grant_d
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_D_STREAK);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_bus_valid;
    logic        w_bus_valid_nxt;
    logic [31:0] r_bus_addr;
    logic [31:0] w_bus_addr_nxt;
    logic [31:0] r_bus_wrdata;
    logic [31:0] w_bus_wrdata_nxt;
    logic [3:0]  r_bus_wrstb;
    logic [3:0]  w_bus_wrstb_nxt;
    logic        r_imem_ready;
    logic        w_imem_ready_nxt;
    logic        r_dmem_ready;
    logic        w_dmem_ready_nxt;
    logic [31:0] r_imem_rdata;
    logic [31:0] w_imem_rdata_nxt;
    logic [31:0] r_dmem_rdata;
    logic [31:0] w_dmem_rdata_nxt;
    logic        r_grant_d;
    logic        w_grant_d_nxt;
    logic [3:0]  r_streak;
    logic [3:0]  w_streak_nxt;

    // Next-state and next-register computation; everything holds unless a rule fires.
    always_comb begin
        w_state_nxt      = r_state;
        w_bus_valid_nxt  = r_bus_valid;
        w_bus_addr_nxt   = r_bus_addr;
        w_bus_wrdata_nxt = r_bus_wrdata;
        w_bus_wrstb_nxt  = r_bus_wrstb;
        w_imem_ready_nxt = 1'b0;
        w_dmem_ready_nxt = 1'b0;
        w_imem_rdata_nxt = r_imem_rdata;
        w_dmem_rdata_nxt = r_dmem_rdata;
        w_grant_d_nxt    = r_grant_d;
        w_streak_nxt     = r_streak;
        case (r_state)
            ST_IDLE: begin
                // DMEM wins unless fetch has waited through a full streak.
                if (dmem_req && !(imem_req && (r_streak == LP_MAX_STREAK))) begin
                    w_state_nxt      = ST_BUSY;
                    w_bus_valid_nxt  = 1'b1;
                    w_bus_addr_nxt   = dmem_addr;
                    w_bus_wrdata_nxt = dmem_wrdata;
                    w_bus_wrstb_nxt  = dmem_wrstb;
                    w_grant_d_nxt    = 1'b1;
                    if (imem_req) begin
                        if (r_streak < LP_MAX_STREAK) begin
                            w_streak_nxt = r_streak + 4'd1;
                        end else begin
                            w_streak_nxt = r_streak;
                        end
                    end else begin
                        w_streak_nxt = 4'd0;
                    end
                end else if (imem_req) begin
                    w_state_nxt      = ST_BUSY;
                    w_bus_valid_nxt  = 1'b1;
                    w_bus_addr_nxt   = imem_addr;
                    w_bus_wrdata_nxt = 32'd0;
                    w_bus_wrstb_nxt  = 4'd0;
                    w_grant_d_nxt    = 1'b0;
                    w_streak_nxt     = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus_ready) begin
                    w_state_nxt     = ST_RESP;
                    w_bus_valid_nxt = 1'b0;
                    if (r_grant_d) begin
                        w_dmem_rdata_nxt = bus_rddata;
                        w_dmem_ready_nxt = 1'b1;
                    end else begin
                        w_imem_rdata_nxt = bus_rddata;
                        w_imem_ready_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_bus_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bus_valid  <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_wrdata <= 32'd0;
            r_bus_wrstb  <= 4'd0;
            r_imem_ready <= 1'b0;
            r_dmem_ready <= 1'b0;
            r_imem_rdata <= 32'd0;
            r_dmem_rdata <= 32'd0;
            r_grant_d    <= 1'b0;
            r_streak     <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_bus_valid  <= w_bus_valid_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_wrdata <= w_bus_wrdata_nxt;
            r_bus_wrstb  <= w_bus_wrstb_nxt;
            r_imem_ready <= w_imem_ready_nxt;
            r_dmem_ready <= w_dmem_ready_nxt;
            r_imem_rdata <= w_imem_rdata_nxt;
            r_dmem_rdata <= w_dmem_rdata_nxt;
            r_grant_d    <= w_grant_d_nxt;
            r_streak     <= w_streak_nxt;
        end
    end

    assign bus_valid  = r_bus_valid;
    assign bus_addr   = r_bus_addr;
    assign bus_wrdata = r_bus_wrdata;
    assign bus_wrstb  = r_bus_wrstb;
    assign imem_ready = r_imem_ready;
    assign dmem_ready = r_dmem_ready;
    assign imem_rdata = r_imem_rdata;
    assign dmem_rdata = r_dmem_rdata;
    assign grant_d    = r_grant_d;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a transaction-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mem_arb;

    localparam int MAXS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wrdata;
    logic [3:0]  dmem_wrstb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic [3:0]  bus_wrstb;
    logic [31:0] bus_rddata;
    logic        bus_ready;
    logic        grant_d;

    always #5 clk = ~clk;

    mem_arb #(.MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wrdata(dmem_wrdata), .dmem_wrstb(dmem_wrstb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wrstb(bus_wrstb),
        .bus_rddata(bus_rddata), .bus_ready(bus_ready), .grant_d(grant_d)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction, one pending response pulse.
    bit          m_on = 1'b0;
    logic        m_valid, m_own_d, m_pi, m_pd, m_gd, pick_d;
    logic [31:0] m_addr, m_wd, m_rdi, m_rdd;
    logic [3:0]  m_ws;
    int          m_streak;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_on = 1'b1; m_valid = 1'b0; m_own_d = 1'b0; m_pi = 1'b0; m_pd = 1'b0; m_gd = 1'b0;
            m_addr = 32'd0; m_wd = 32'd0; m_ws = 4'd0; m_rdi = 32'd0; m_rdd = 32'd0; m_streak = 0;
        end else if (m_pi || m_pd) begin
            m_pi = 1'b0; m_pd = 1'b0;
        end else if (m_valid) begin
            if (bus_ready) begin
                if (m_own_d) m_rdd = bus_rddata; else m_rdi = bus_rddata;
                m_pd = m_own_d; m_pi = !m_own_d; m_valid = 1'b0;
            end
        end else if (imem_req || dmem_req) begin
            pick_d = dmem_req && !(imem_req && m_streak == MAXS);
            if (pick_d) begin
                m_streak = imem_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                m_addr = dmem_addr; m_wd = dmem_wrdata; m_ws = dmem_wrstb;
            end else begin
                m_streak = 0; m_addr = imem_addr; m_wd = 32'd0; m_ws = 4'd0;
            end
            m_valid = 1'b1; m_gd = pick_d; m_own_d = pick_d;
        end
    end

    // Every-cycle comparison against the model, plus grant-order recording.
    bit   rec_on = 1'b0;
    logic prev_bv = 1'b0;
    bit   g_q[$];

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("m_bus_valid", 32'(bus_valid), 32'(m_valid));
            chk("m_bus_addr", bus_addr, m_addr);
            chk("m_bus_wrdata", bus_wrdata, m_wd);
            chk("m_bus_wrstb", 32'(bus_wrstb), 32'(m_ws));
            chk("m_imem_ready", 32'(imem_ready), 32'(m_pi));
            chk("m_dmem_ready", 32'(dmem_ready), 32'(m_pd));
            chk("m_imem_rdata", imem_rdata, m_rdi);
            chk("m_dmem_rdata", dmem_rdata, m_rdd);
            chk("m_grant_d", 32'(grant_d), 32'(m_gd));
            if (rec_on && bus_valid && !prev_bv) g_q.push_back(grant_d);
        end
        prev_bv = bus_valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid;
        int n = 0;
        while (bus_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (bus_valid !== 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_valid timeout actual=%b required=1", bus_valid);
        end
    endtask

    // Acknowledge the next bus transaction after the given number of wait cycles.
    task automatic bus_serve(input int waits, input logic [31:0] data);
        wait_valid();
        repeat (waits) tick();
        bus_rddata = data;
        bus_ready  = 1'b1;
        tick();
        bus_ready  = 1'b0;
    endtask

    bit exp_g [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat;

    initial begin
        rst_n = 1'b0; imem_req = 1'b0; imem_addr = 32'd0; dmem_req = 1'b0; dmem_addr = 32'd0;
        dmem_wrdata = 32'd0; dmem_wrstb = 4'd0; bus_rddata = 32'd0; bus_ready = 1'b0;
        tick(); tick();
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_readies", 32'({imem_ready, dmem_ready}), 32'd0);
        chk("rst_rdata", imem_rdata | dmem_rdata, 32'd0);
        chk("rst_grant_d", 32'(grant_d), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch, zero-wait bus.
        imem_req = 1'b1; imem_addr = 32'h0000_0010;
        wait_valid();
        chk("fetch_bus_addr", bus_addr, 32'h10);
        chk("fetch_bus_wrstb", 32'(bus_wrstb), 32'd0);
        bus_rddata = 32'hDEAD_BEEF; bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0; imem_req = 1'b0;
        chk("fetch_valid_1cyc", 32'(bus_valid), 32'd0);
        chk("fetch_ready", 32'(imem_ready), 32'd1);
        chk("fetch_rdata", imem_rdata, 32'hDEAD_BEEF);
        chk("fetch_no_dready", 32'(dmem_ready), 32'd0);
        tick();
        chk("fetch_ready_pulse", 32'(imem_ready), 32'd0);
        tick();

        // Store with 3 wait cycles.
        dmem_req = 1'b1; dmem_addr = 32'h100; dmem_wrdata = 32'h1234_5678; dmem_wrstb = 4'b0011;
        lat = 1;
        tick(); lat++;
        for (int i = 0; i < 4; i++) begin
            chk("store_valid", 32'(bus_valid), 32'd1);
            chk("store_addr", bus_addr, 32'h100);
            chk("store_wrdata", bus_wrdata, 32'h1234_5678);
            chk("store_wrstb", 32'(bus_wrstb), 32'h3);
            chk("store_no_ready", 32'(dmem_ready), 32'd0);
            if (i == 3) begin
                bus_rddata = 32'hCAFE_F00D; bus_ready = 1'b1;
            end
            tick(); lat++;
        end
        bus_ready = 1'b0; dmem_req = 1'b0; dmem_wrstb = 4'd0;
        chk("store_ready", 32'(dmem_ready), 32'd1);
        chk("store_latency", 32'(lat), 32'd6);
        chk("store_imem_rdata_held", imem_rdata, 32'hDEAD_BEEF);
        tick(); tick();

        // bus_ready with nothing on the bus is ignored.
        bus_ready = 1'b1; tick(); tick();
        bus_ready = 1'b0;
        chk("stray_ready_valid", 32'(bus_valid), 32'd0);
        chk("stray_ready_pulse", 32'({imem_ready, dmem_ready}), 32'd0);
        tick();

        // Simultaneous requests held continuously: D, D, I, D, D, I.
        imem_addr = 32'h300; dmem_addr = 32'h200;
        imem_req = 1'b1; dmem_req = 1'b1; rec_on = 1'b1;
        for (int i = 0; i < 6; i++) bus_serve(0, 32'hA000_0000 + 32'(i));
        imem_req = 1'b0; dmem_req = 1'b0;
        tick(); tick();
        rec_on = 1'b0;
        chk("order_count", 32'(g_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < g_q.size()) chk("order_grant", 32'(g_q[i]), 32'(exp_g[i]));
        end

        // Streak reset: build a streak, clear it with a lone DMEM grant, then both request.
        imem_req = 1'b1; dmem_req = 1'b1;
        bus_serve(0, 32'h1); bus_serve(0, 32'h2);
        imem_req = 1'b0;
        bus_serve(0, 32'h3);
        imem_req = 1'b1;
        wait_valid();
        chk("streak_clr_grant_d", 32'(grant_d), 32'd1);
        chk("streak_clr_addr", bus_addr, 32'h200);
        bus_serve(0, 32'h4);
        dmem_req = 1'b0;
        bus_serve(0, 32'h5);
        chk("streak_i_served", imem_rdata, 32'h5);
        imem_req = 1'b0;
        tick(); tick();

        // Requester drops req during BUSY.
        imem_req = 1'b1; imem_addr = 32'h80;
        wait_valid();
        tick();
        imem_req = 1'b0;
        bus_serve(2, 32'h1111_2222);
        chk("drop_ready", 32'(imem_ready), 32'd1);
        chk("drop_rdata", imem_rdata, 32'h1111_2222);
        tick();
        chk("drop_ready_once", 32'(imem_ready), 32'd0);
        tick(); tick();

        // Reset during BUSY abandons the transaction.
        imem_req = 1'b1; imem_addr = 32'h40;
        wait_valid();
        rst_n = 1'b0; imem_req = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstb_valid", 32'(bus_valid), 32'd0);
        chk("rstb_readies", 32'({imem_ready, dmem_ready}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rstb_no_pulse", 32'({imem_ready, dmem_ready}), 32'd0);
            tick();
        end
        imem_req = 1'b1; imem_addr = 32'h44;
        bus_serve(1, 32'h0BAD_F00D);
        imem_req = 1'b0;
        chk("rstb_refetch_ready", 32'(imem_ready), 32'd1);
        chk("rstb_refetch_rdata", imem_rdata, 32'h0BAD_F00D);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
